// File: rtl/mpc_link_align_ctrl.sv
// MPC fiber BC0 alignment controller: resets the GTH rx buffers, waits for byte lock,
// measures each fiber's BC0 latency over two orbits and programs the per-fiber delay lines.

module mpc_align_lane (
  input  logic       clk_160,
  input  logic       soft_reset,
  input  logic       clr_i,
  input  logic       meas_i,
  input  logic       armed_i,
  input  logic       pass2_i,
  input  logic       ref_bc0_i,
  input  logic       bc0_i,
  input  logic [7:0] cnt_i,
  output logic [7:0] lat_o,
  output logic       bad_o
);
  logic       prev_q, cap1_q, cap2_q, coll_q;
  logic [7:0] lat1_q, lat2_q;
  logic       rise;

  assign rise = bc0_i & ~prev_q;

  always_ff @(posedge clk_160) begin
    if (soft_reset) begin
      prev_q <= 1'b0;
      cap1_q <= 1'b0;
      cap2_q <= 1'b0;
      coll_q <= 1'b0;
      lat1_q <= '0;
      lat2_q <= '0;
    end else begin
      prev_q <= bc0_i;
      if (clr_i) begin
        cap1_q <= 1'b0;
        cap2_q <= 1'b0;
        coll_q <= 1'b0;
      end else if (meas_i && rise) begin
        // an edge coincident with the reference cannot be assigned a latency
        if (ref_bc0_i) coll_q <= 1'b1;
        else if (armed_i && !pass2_i && !cap1_q) begin
          cap1_q <= 1'b1;
          lat1_q <= cnt_i;
        end else if (armed_i && pass2_i && !cap2_q) begin
          cap2_q <= 1'b1;
          lat2_q <= cnt_i;
        end
      end
    end
  end

  assign lat_o = lat1_q;
  assign bad_o = ~cap1_q | ~cap2_q | coll_q | (lat1_q != lat2_q);
endmodule

module mpc_link_align_ctrl #(
  parameter int          FC          = 9,
  parameter int          BUFRST_CLKS = 16,
  parameter logic [15:0] LOCK_TMO    = 16'hffff
) (
  input  logic                 clk_160,
  input  logic                 soft_reset,
  input  logic                 start,
  input  logic [FC-1:0]        fiber_enable,
  input  logic [FC-1:0]        rxbyteisaligned,
  input  logic                 ref_bc0,
  input  logic [FC-1:0]        bc0_u_af,
  input  logic [5:0]           margin,
  output logic [FC-1:0][7:0]   af_delays,
  output logic                 rxbufreset,
  output logic                 busy,
  output logic                 done,
  output logic [FC-1:0]        align_err,
  output logic                 timeout_err
);
  localparam int IW = (FC > 1) ? $clog2(FC) : 1;

  typedef enum logic [2:0] {
    IDLE, BUFRST, WAIT_ALIGN, MEAS1, MEAS2, COMPUTE, APPLY, DONE
  } state_e;

  state_e               state_q, state_d;
  logic [15:0]          tmr_q;
  logic [7:0]           cnt_q;
  logic                 armed_q;
  logic [IW-1:0]        idx_q;
  logic [7:0]           max_q;
  logic                 vld_q;
  logic [FC-1:0][5:0]   af_q;
  logic [FC-1:0]        aerr_q;
  logic                 terr_q;

  logic [FC-1:0][7:0]   lat_w, dly_w;
  logic [FC-1:0]        bad_w, err_new;
  logic [FC-1:0][5:0]   af_new;
  logic                 in_meas, pass_end, aligned, run_clr;

  assign in_meas  = (state_q == MEAS1) || (state_q == MEAS2);
  assign pass_end = in_meas && armed_q && (ref_bc0 || cnt_q == 8'hff);
  assign aligned  = &(rxbyteisaligned | ~fiber_enable);
  assign run_clr  = (state_q == IDLE) && start;

  mpc_align_lane u_lane [FC-1:0] (
    .clk_160   (clk_160),
    .soft_reset(soft_reset),
    .clr_i     (run_clr),
    .meas_i    (in_meas),
    .armed_i   (armed_q),
    .pass2_i   (state_q == MEAS2),
    .ref_bc0_i (ref_bc0),
    .bc0_i     (bc0_u_af),
    .cnt_i     (cnt_q),
    .lat_o     (lat_w),
    .bad_o     (bad_w)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (start) state_d = BUFRST;
      BUFRST:     if (tmr_q == 16'(BUFRST_CLKS - 1)) state_d = WAIT_ALIGN;
      WAIT_ALIGN: if (aligned) state_d = MEAS1;
                  else if (tmr_q == LOCK_TMO - 16'd1) state_d = DONE;
      MEAS1:      if (pass_end) state_d = MEAS2;
      MEAS2:      if (pass_end) state_d = COMPUTE;
      COMPUTE:    if (idx_q == IW'(FC - 1)) state_d = APPLY;
      APPLY:      state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // delay programming; with no valid reference every enabled fiber is flagged
  always_comb begin
    dly_w   = '0;
    af_new  = '0;
    err_new = '0;
    for (int i = 0; i < FC; i++) begin
      dly_w[i]   = max_q - lat_w[i] + {2'b00, margin};
      err_new[i] = fiber_enable[i];
      if (vld_q) begin
        err_new[i] = aerr_q[i];
        if (fiber_enable[i] && !aerr_q[i]) begin
          if (dly_w[i] > 8'd63) begin
            af_new[i]  = 6'd63;
            err_new[i] = 1'b1;
          end else begin
            af_new[i] = dly_w[i][5:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_160) begin
    if (soft_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk_160) begin
    if (soft_reset) begin
      tmr_q   <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      idx_q   <= '0;
      max_q   <= '0;
      vld_q   <= 1'b0;
      af_q    <= '0;
      aerr_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      tmr_q <= (state_d != state_q || state_q == IDLE) ? 16'd0 : tmr_q + 16'd1;
      // a pass that runs out at 255 leaves the counter disarmed until the next reference
      if (in_meas) begin
        if (ref_bc0) begin
          armed_q <= 1'b1;
          cnt_q   <= '0;
        end else if (armed_q) begin
          if (cnt_q == 8'hff) armed_q <= 1'b0;
          else                cnt_q   <= cnt_q + 8'd1;
        end
      end else begin
        armed_q <= 1'b0;
        cnt_q   <= '0;
      end
      if (run_clr) begin
        aerr_q <= '0;
        terr_q <= 1'b0;
      end
      if (state_q == WAIT_ALIGN && state_d == DONE) terr_q <= 1'b1;
      if (state_q == MEAS2 && state_d == COMPUTE) begin
        aerr_q <= fiber_enable & bad_w;
        idx_q  <= '0;
        max_q  <= '0;
        vld_q  <= 1'b0;
      end
      if (state_q == COMPUTE) begin
        if (fiber_enable[idx_q] && !aerr_q[idx_q] && (!vld_q || lat_w[idx_q] > max_q)) begin
          max_q <= lat_w[idx_q];
          vld_q <= 1'b1;
        end
        idx_q <= idx_q + IW'(1);
      end
      if (state_q == APPLY) begin
        af_q   <= af_new;
        aerr_q <= err_new;
      end
    end
  end

  always_comb begin
    af_delays = '0;
    for (int i = 0; i < FC; i++) af_delays[i] = {2'b00, af_q[i]};
  end

  assign rxbufreset  = (state_q == BUFRST);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign align_err   = aerr_q;
  assign timeout_err = terr_q;
endmodule

// File: doc/mpc_link_align_ctrl.md
MPC_LINK_ALIGN_CTRL -- requirements
Module: mpc_link_align_ctrl

Interface
REQ-001 SHALL have parameter FC, default 9, which is the number of MPC fibers.
REQ-002 SHALL have parameter BUFRST_CLKS, default 16, which is the rxbufreset pulse length in clocks.
REQ-003 SHALL have parameter LOCK_TMO, default 16'hffff, which is the byte-alignment wait timeout in clocks.
REQ-004 SHALL have port clk_160, input, 1 bit: the only clock.
REQ-005 SHALL have port soft_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: one-clock pulse that requests an alignment run.
REQ-007 SHALL have port fiber_enable, input, FC bits: per-fiber participation.
REQ-008 SHALL have port rxbyteisaligned, input, FC bits: per-fiber GTH byte-alignment status.
REQ-009 SHALL have port ref_bc0, input, 1 bit: reference BC0 pulse, one per orbit.
REQ-010 SHALL have port bc0_u_af, input, FC bits: per-fiber BC0 taken before the alignment delay line.
REQ-011 SHALL have port margin, input, 6 bits: extra delay added to every enabled fiber.
REQ-012 SHALL have port af_delays, output, 8 bits x FC: delay-line select per fiber; bits [7:6] are always 0.
REQ-013 SHALL have port rxbufreset, output, 1 bit: receive buffer reset request to all fibers.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-clock pulse when a run completes.
REQ-016 SHALL have port align_err, output, FC bits: per-fiber failure flags from the last run.
REQ-017 SHALL have port timeout_err, output, 1 bit: byte-alignment wait expired in the last run.

Function
REQ-018 SHALL implement the FSM states IDLE, BUFRST, WAIT_ALIGN, MEAS1, MEAS2, COMPUTE, APPLY and DONE.
REQ-019 SHALL, in IDLE, move to BUFRST on start; start is ignored in every other state.
REQ-020 SHALL, on entry to BUFRST, clear align_err and timeout_err.
REQ-021 SHALL hold rxbufreset high for exactly BUFRST_CLKS clocks in BUFRST, then go to WAIT_ALIGN.
REQ-022 SHALL leave WAIT_ALIGN for MEAS1 once (rxbyteisaligned | ~fiber_enable) is all ones.
REQ-023 SHALL, in WAIT_ALIGN, set timeout_err and go to DONE if that condition is not met within LOCK_TMO clocks.
REQ-024 SHALL, in MEAS1 and MEAS2, start an 8-bit latency counter at 0 on ref_bc0; before the first ref_bc0 of a pass, fiber BC0s are ignored.
REQ-025 SHALL increment the latency counter every clock and saturate it at 255.
REQ-026 SHALL, on the first rising edge of bc0_u_af[i] within a pass, capture the latency counter value as lat_i for that pass; later edges in the same pass are ignored.
REQ-027 SHALL end a pass on the next ref_bc0 or when the counter reaches 255, whichever comes first.
REQ-028 SHALL treat a ref_bc0 that ends MEAS1 as the start of MEAS2.
REQ-029 SHALL, when a pass ends at counter 255, wait in a sub-state for the next ref_bc0 before starting MEAS2.
REQ-030 SHALL set align_err[i] for an enabled fiber with no capture in either pass, or whose two lat_i values differ.
REQ-031 SHALL set align_err[i] for an enabled fiber when the BC0 edge and ref_bc0 occur in the same clock, and treat that fiber as not captured.
REQ-032 SHALL, in COMPUTE, scan the fibers one per clock (FC clocks) to find max_lat over enabled fibers without errors.
REQ-033 SHALL compute delay_i = max_lat - lat_i + margin at 8-bit width.
REQ-034 SHALL set align_err[i] and saturate delay_i to 63 when delay_i exceeds 63.
REQ-035 SHALL, in APPLY, update all af_delays in a single clock.
REQ-036 SHALL write 0 in APPLY for disabled fibers and for fibers with align_err set.
REQ-037 SHALL, if no valid fiber exists, write all af_delays to 0 and set align_err for every enabled fiber.
REQ-038 SHALL, on a timeout path, leave af_delays unchanged.
REQ-039 SHALL, in DONE, pulse done for one clock and then return to IDLE.
REQ-040 SHALL hold af_delays between runs.
REQ-041 SHALL hold align_err and timeout_err until the next run.

Reset
REQ-042 SHALL, with soft_reset high at a clock edge, set the FSM to IDLE and all counters to 0.
REQ-043 SHALL, with soft_reset high at a clock edge, set af_delays to 0, and rxbufreset, busy, done, align_err and timeout_err to 0.
REQ-044 SHALL, when reset occurs mid-run, abort the run with no done pulse and no further af_delays update.
REQ-045 SHALL give soft_reset priority over a start in the same clock.

Verification
REQ-046 SHALL cover nominal alignment: FC=3, all fibers enabled, margin=2, BC0 latencies 5/9/7 in both passes -> af_delays 6/2/4, align_err=0, and one done pulse.
REQ-047 SHALL cover inconsistent latency: fiber 1 latency 9 then 10 -> align_err[1]=1 and af_delays[1]=0, with the other fibers computed from max_lat=7.
REQ-048 SHALL cover timeout: rxbyteisaligned[2]=0 with fiber 2 enabled -> timeout_err=1 and done after BUFRST_CLKS+LOCK_TMO clocks, af_delays unchanged; repeating with fiber 2 disabled -> no timeout.
REQ-049 SHALL cover saturation: latencies 0 and 70, margin=0 -> fiber 0 delay 70 saturates to 63 with align_err[0]=1; fiber 1 delay 0.
REQ-050 SHALL cover reset during MEAS1: soft_reset for one clock -> busy=0, af_delays=0, no done; a following start completes a normal run.
REQ-051 SHALL cover a missing BC0: fiber 0 never pulses -> align_err[0]=1, af_delays[0]=0, and the run still completes.
